// File: rtl/btb_tag_valid_ctrl.sv
// BTB tag/valid RAM port controller: lookup, buffered update, clearing sweep.
// Optional macro BTB_TV_BYPASS_EN forwards the pending update to lookups.
module btb_tag_valid_ctrl #(
    parameter int INDEX_W    = 10,
    parameter int TAG_W      = 22,
    parameter int STARVE_MAX = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_lookup_en,
    input  logic [31:0]        i_lookup_pc,
    output logic               o_lookup_hit,
    output logic               o_lookup_stall,
    input  logic               i_upd_req,
    input  logic [31:0]        i_upd_pc,
    input  logic               i_upd_valid,
    output logic               o_upd_ready,
    input  logic               i_flush,
    output logic               o_busy,
    output logic               o_ram_wren,
    output logic [INDEX_W-1:0] o_ram_addr,
    output logic [TAG_W:0]     o_ram_wdata,
    input  logic [TAG_W:0]     i_ram_rdata
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        INIT,
        RUN,
        FLUSH
    } state_t;

    state_t             state;
    logic [INDEX_W-1:0] sweep_idx;
    logic               buf_full;
    logic               buf_vld;
    logic [INDEX_W-1:0] buf_idx;
    logic [TAG_W-1:0]   buf_tag;
    logic [SC_W-1:0]    starve_cnt;

    logic               run;
    logic               forced;
    logic               grant;
    logic               accept;
    logic [INDEX_W-1:0] lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic               ent_vld;
    logic [TAG_W-1:0]   ent_tag;
    logic               unused;

    assign unused = ^{i_lookup_pc[1:0], i_upd_pc[1:0]};

    assign lk_idx = i_lookup_pc[INDEX_W+1:2];
    assign lk_tag = TAG_W'(i_lookup_pc[31:12]);

    assign run    = (state == RUN);
    assign forced = (starve_cnt == SC_W'(STARVE_MAX));
    // Flush discards the buffer, so it never drains in the flush cycle.
    assign grant  = run & buf_full & ~i_flush & (~i_lookup_en | forced);

    assign o_upd_ready    = run & ~i_flush & (~buf_full | grant);
    assign accept         = i_upd_req & o_upd_ready;
    assign o_lookup_stall = grant & i_lookup_en;
    assign o_busy         = ~run;

`ifdef BTB_TV_BYPASS_EN
    logic byp;
    assign byp     = buf_full & (buf_idx == lk_idx);
    assign ent_vld = byp ? buf_vld : i_ram_rdata[TAG_W];
    assign ent_tag = byp ? buf_tag : i_ram_rdata[TAG_W-1:0];
`else
    assign ent_vld = i_ram_rdata[TAG_W];
    assign ent_tag = i_ram_rdata[TAG_W-1:0];
`endif

    assign o_lookup_hit = run & i_lookup_en & ~o_lookup_stall
                        & ent_vld & (ent_tag == lk_tag);

    always_comb begin
        o_ram_wren  = 1'b0;
        o_ram_addr  = lk_idx;
        o_ram_wdata = '0;
        if (!run) begin
            o_ram_wren = 1'b1;
            o_ram_addr = sweep_idx;
        end else if (grant) begin
            o_ram_wren  = 1'b1;
            o_ram_addr  = buf_idx;
            o_ram_wdata = {buf_vld, buf_tag};
        end
        if (!i_rst_n) begin
            o_ram_wren = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= INIT;
            sweep_idx  <= '0;
            buf_full   <= 1'b0;
            buf_vld    <= 1'b0;
            buf_idx    <= '0;
            buf_tag    <= '0;
            starve_cnt <= '0;
        end else begin
            unique case (state)
                INIT, FLUSH: begin
                    if (i_flush) begin
                        sweep_idx <= '0;
                    end else begin
                        sweep_idx <= sweep_idx + 1'b1;
                        if (&sweep_idx) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (i_flush) begin
                        state      <= FLUSH;
                        sweep_idx  <= '0;
                        buf_full   <= 1'b0;
                        starve_cnt <= '0;
                    end else begin
                        if (grant) begin
                            starve_cnt <= '0;
                        end else if (buf_full & i_lookup_en) begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                        if (accept) begin
                            buf_full <= 1'b1;
                            buf_vld  <= i_upd_valid;
                            buf_idx  <= i_upd_pc[INDEX_W+1:2];
                            buf_tag  <= TAG_W'(i_upd_pc[31:12]);
                        end else if (grant) begin
                            buf_full <= 1'b0;
                        end
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_btb_tag_valid_ctrl.sv
// Randomised and directed bench for btb_tag_valid_ctrl with a RAM model
// and a table-level reference model of the BTB contents.
module tb_btb_tag_valid_ctrl;

    localparam int SMAX = 4;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_lookup_en;
    logic [31:0] i_lookup_pc;
    logic        o_lookup_hit;
    logic        o_lookup_stall;
    logic        i_upd_req;
    logic [31:0] i_upd_pc;
    logic        i_upd_valid;
    logic        o_upd_ready;
    logic        i_flush;
    logic        o_busy;
    logic        o_ram_wren;
    logic [9:0]  o_ram_addr;
    logic [22:0] o_ram_wdata;
    logic [22:0] i_ram_rdata;

    int checks = 0;
    int errors = 0;

    btb_tag_valid_ctrl dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_lookup_en   (i_lookup_en),
        .i_lookup_pc   (i_lookup_pc),
        .o_lookup_hit  (o_lookup_hit),
        .o_lookup_stall(o_lookup_stall),
        .i_upd_req     (i_upd_req),
        .i_upd_pc      (i_upd_pc),
        .i_upd_valid   (i_upd_valid),
        .o_upd_ready   (o_upd_ready),
        .i_flush       (i_flush),
        .o_busy        (o_busy),
        .o_ram_wren    (o_ram_wren),
        .o_ram_addr    (o_ram_addr),
        .o_ram_wdata   (o_ram_wdata),
        .i_ram_rdata   (i_ram_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // RAM: write on posedge, registered read on negedge, garbage at start
    logic [22:0] mem [1024];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 23'($urandom);
        i_ram_rdata = '0;
    end
    always @(posedge i_clk) if (o_ram_wren) mem[o_ram_addr] <= o_ram_wdata;
    always @(negedge i_clk) i_ram_rdata <= mem[o_ram_addr];

    // Reference model: table contents, one pending update, sweep progress
    bit          m_busy;
    int          m_si;
    bit          p_full;
    bit          p_vld;
    int          p_idx;
    logic [21:0] p_tag;
    int          m_st;
    bit          tv [1024];
    logic [21:0] tt [1024];

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc[11:2]);
    endfunction

    function automatic logic [21:0] tag_of(input logic [31:0] pc);
        return {2'b00, pc[31:12]};
    endfunction

    task automatic chk(input string tg, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tg, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b1;
        m_si   = 0;
        p_full = 1'b0;
        m_st   = 0;
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic cycle(input bit len, input logic [31:0] lpc,
                         input bit ureq, input logic [31:0] upc,
                         input bit uval, input bit fl);
        bit          e_grant, e_rdy, e_stall, e_hit, e_wren, ev;
        int          e_addr, li;
        logic [22:0] e_wdata;
        logic [21:0] et;
        i_lookup_en = len;
        i_lookup_pc = lpc;
        i_upd_req   = ureq;
        i_upd_pc    = upc;
        i_upd_valid = uval;
        i_flush     = fl;
        li      = idx_of(lpc);
        e_grant = 1'b0;
        if (m_busy) begin
            e_wren  = 1'b1;
            e_addr  = m_si;
            e_wdata = '0;
            e_rdy   = 1'b0;
            e_stall = 1'b0;
            e_hit   = 1'b0;
        end else begin
            e_grant = p_full && !fl && (!len || m_st == SMAX);
            e_rdy   = !fl && (!p_full || e_grant);
            e_stall = e_grant && len;
            e_wren  = e_grant;
            e_addr  = e_grant ? p_idx : li;
            e_wdata = {p_vld, p_tag};
            ev = tv[li];
            et = tt[li];
`ifdef BTB_TV_BYPASS_EN
            if (p_full && p_idx == li) begin
                ev = p_vld;
                et = p_tag;
            end
`endif
            e_hit = len && !e_stall && ev && (et == tag_of(lpc));
        end
        #6;
        chk("busy", 32'(o_busy), 32'(m_busy));
        chk("ready", 32'(o_upd_ready), 32'(e_rdy));
        chk("stall", 32'(o_lookup_stall), 32'(e_stall));
        chk("hit", 32'(o_lookup_hit), 32'(e_hit));
        chk("wren", 32'(o_ram_wren), 32'(e_wren));
        if (e_wren || len) chk("addr", 32'(o_ram_addr), 32'(e_addr));
        if (e_wren) chk("wdata", 32'(o_ram_wdata), 32'(e_wdata));
        if (m_busy) begin
            tv[m_si] = 1'b0;
            if (fl) m_si = 0;
            else if (m_si == 1023) m_busy = 1'b0;
            else m_si++;
        end else if (fl) begin
            m_busy = 1'b1;
            m_si   = 0;
            p_full = 1'b0;
            m_st   = 0;
        end else begin
            if (e_grant) begin
                tv[p_idx] = p_vld;
                tt[p_idx] = p_tag;
                p_full    = 1'b0;
                m_st      = 0;
            end else if (p_full && len) begin
                m_st++;
            end
            if (ureq && e_rdy) begin
                p_full = 1'b1;
                p_vld  = uval;
                p_idx  = idx_of(upc);
                p_tag  = tag_of(upc);
            end
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 32'h0, 0, 32'h0, 0, 0);
    endtask

    task automatic look(input logic [31:0] pc, input int n);
        for (int k = 0; k < n; k++) cycle(1, pc, 0, 32'h0, 0, 0);
    endtask

    task automatic do_reset();
        i_rst_n     = 1'b0;
        i_lookup_en = 1'b0;
        i_upd_req   = 1'b0;
        i_flush     = 1'b0;
        #1;
        chk("rst_wren", 32'(o_ram_wren), 32'd0);
        chk("rst_addr", 32'(o_ram_addr), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd1);
        chk("rst_hit", 32'(o_lookup_hit), 32'd0);
        chk("rst_stall", 32'(o_lookup_stall), 32'd0);
        chk("rst_ready", 32'(o_upd_ready), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        model_reset();
    endtask

    function automatic logic [31:0] rnd_pc();
        logic [31:0] p;
        p = (32'($urandom_range(0, 3)) << 12)
          | (32'($urandom_range(0, 7)) << 2)
          | 32'($urandom_range(0, 3));
        return p;
    endfunction

    initial begin
        i_rst_n     = 1'b0;
        i_lookup_en = 1'b0;
        i_lookup_pc = '0;
        i_upd_req   = 1'b0;
        i_upd_pc    = '0;
        i_upd_valid = 1'b0;
        i_flush     = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            tv[i] = 1'b0;
            tt[i] = '0;
        end
        model_reset();
        @(posedge i_clk);
        #1;
        do_reset();
        // Initial sweep, then lookup of an empty table
        idle(1024);
        look(32'h0000_1234, 1);
        // Install with fetch idle, then hit and tag-mismatch miss
        cycle(0, 32'h0, 1, 32'h0000_1234, 1, 0);
        idle(1);
        look(32'h0000_1234, 2);
        look(32'h0000_5234, 1);
        // Starvation: update behind continuous lookups
        cycle(1, 32'h0000_1234, 1, 32'h0000_3000, 1, 0);
        look(32'h0000_1234, SMAX + 3);
        // Install then look up the same PC while pending
        cycle(1, 32'h0000_1234, 1, 32'h0000_2000, 1, 0);
        look(32'h0000_2000, SMAX + 3);
        // Back-to-back updates with fetch idle, then invalidate
        cycle(0, 32'h0, 1, 32'h0000_1238, 1, 0);
        cycle(0, 32'h0, 1, 32'h0001_123c, 1, 0);
        cycle(0, 32'h0, 1, 32'h0000_1234, 0, 0);
        idle(1);
        look(32'h0000_1234, 1);
        look(32'h0000_1238, 1);
        look(32'h0001_123c, 1);
        // Full buffer plus flush with simultaneous update request
        cycle(1, 32'h0000_1238, 1, 32'h0000_4000, 1, 0);
        cycle(1, 32'h0000_1238, 1, 32'h0000_6000, 1, 1);
        idle(1024);
        look(32'h0000_4000, 1);
        look(32'h0000_6000, 1);
        look(32'h0000_1238, 1);
        // Reset in the middle of a sweep
        cycle(0, 32'h0, 0, 32'h0, 0, 1);
        while (m_si != 500) idle(1);
        do_reset();
        idle(1024);
        // Randomised traffic against the model
        for (int n = 0; n < 600; n++) begin
            cycle(1'($urandom_range(0, 1)), rnd_pc(),
                  ($urandom_range(0, 2) != 0), rnd_pc(),
                  ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 299) == 0));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/btb_tag_valid_ctrl.md
# btb_tag_valid_ctrl

Controller for the single-port BTB tag/valid RAM (1024 × 23 bits, synchronous write on posedge, registered read on negedge). It shares the RAM port between two requesters: the fetch-stage lookup, which is combinational within the cycle, and the execute-stage install/invalidate updates, which are buffered. It also runs a clearing sweep after reset and on pipeline flush request, so valid bits never depend on memory initialisation files.

## Interface
- INDEX_W, 10, RAM index width; index = pc[INDEX_W+1:2]
- TAG_W, 22, stored tag width; tag = zero-extended pc[31:12]
- STARVE_MAX, 4, maximum cycles a pending update waits behind lookups
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_lookup_en  in  1  fetch requests a lookup this cycle
- i_lookup_pc  in  32  fetch PC
- o_lookup_hit  out  1  entry valid and tag matches (valid late in the same cycle)
- o_lookup_stall  out  1  port taken by a forced update write; fetch must hold its PC
- i_upd_req  in  1  execute offers an update
- i_upd_pc  in  32  PC of the resolved branch
- i_upd_valid  in  1  1 = install entry, 0 = invalidate entry
- o_upd_ready  out  1  update accepted when high together with i_upd_req
- i_flush  in  1  request a full clear of the table
- o_busy  out  1  a clearing sweep is in progress
- o_ram_wren, o_ram_addr[INDEX_W-1:0], o_ram_wdata[TAG_W:0]  out  RAM port; wdata = {valid, tag}
- i_ram_rdata  in  TAG_W+1  RAM read data

## Operation
- States: INIT, RUN, FLUSH. Reset enters INIT with sweep_idx=0, pending buffer empty, starve_cnt=0.
- INIT/FLUSH sweep:
  - Each cycle: wren=1, addr=sweep_idx, wdata=0; sweep_idx increments.
  - After index 1023 is written, the FSM moves to RUN.
  - o_busy=1, o_lookup_hit=0, o_lookup_stall=0, o_upd_ready=0.
- RUN:
  - Port default: lookup address, wren=0.
  - o_lookup_hit = i_lookup_en & rdata[TAG_W] & (rdata[TAG_W-1:0] == tag(i_lookup_pc)).
- Pending buffer (1 entry: index, tag, valid bit):
  - o_upd_ready = RUN & ~i_flush & (buffer empty | buffer draining this cycle).
  - An accepted update is written into the buffer.
- Write grant: the buffer drains (wren=1, addr/wdata from the buffer) when it is full in RUN and either:
  - i_lookup_en=0, or
  - starve_cnt == STARVE_MAX. This is a forced steal: o_lookup_stall=1 and o_lookup_hit=0.
- starve_cnt:
  - Increments each RUN cycle with the buffer full and i_lookup_en=1 without a grant.
  - Clears on every drain.
- i_flush:
  - In RUN: the pending buffer is discarded, FLUSH is entered, sweep_idx=0.
  - In INIT/FLUSH: the sweep restarts at 0.
  - If i_flush and i_upd_req are high together, the update is not accepted.
- o_ram_wren is forced to 0 while i_rst_n=0.

## Timing
- Reset values: o_busy=1, o_lookup_hit=0, o_lookup_stall=0, o_upd_ready=0, o_ram_wren=0, o_ram_addr=0.
- The first sweep write occurs on the first posedge after reset deasserts.
- Sweep lasts exactly 1024 cycles. o_busy falls in the cycle after index 1023 is written.
- Update latency: accepted at edge N; earliest RAM write at edge N+1. Worst case under continuous lookups: edge N+1+STARVE_MAX.
- Lookup: address is driven combinationally from i_lookup_pc. Hit is valid after the negedge of the same cycle and is sampled by fetch at the next posedge.
- Back-to-back updates: a new update is accepted in the same cycle the buffer drains, giving full throughput when fetch is idle.
- Reset mid-sweep or mid-update: all state is lost and INIT restarts from index 0.

## Configuration
- BTB_TV_BYPASS_EN defined: a lookup whose index equals the pending buffer index takes valid/tag from the buffer instead of rdata, so a newly installed branch hits before its RAM write.
- Undefined: lookups always use rdata and may return stale data until the drain.

## Test plan
- Release reset, lookup_en=0 -> wren=1 for 1024 consecutive cycles, addrs 0..1023, wdata=0, o_busy=1 throughout; lookup of 0x0000_1234 then returns hit=0.
- After INIT, update pc=0x0000_1234, valid=1, lookup_en=0 -> next cycle wren=1, addr=0x08D, wdata={1,22'h00001}. Later lookup 0x0000_1234 -> hit=1; lookup 0x0000_5234 -> hit=0.
- STARVE_MAX=4, lookup_en held 1, one update accepted at edge N -> no write for 4 cycles, then exactly one cycle with wren=1 and stall=1; stall=0 afterwards.
- BTB_TV_BYPASS_EN, install 0x0000_2000 with lookup_en=1 on the same PC the following cycle -> hit=1 while the entry is still pending. Without the macro, hit=0 until the drain.
- Buffer full plus i_flush with a simultaneous i_upd_req -> ready=0, buffer dropped, 1024-cycle FLUSH sweep runs, and a lookup of the dropped PC afterwards misses.
- Assert i_rst_n=0 at sweep index 500 -> wren=0 immediately; after release the sweep restarts at addr 0.
